instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning program-counter address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction word width.
REQ-003 SHALL have parameter MAX_COUNT, default 4, meaning the number of instructions in the program; it SHALL equal the program counter's limit.
REQ-004 SHALL have parameter FETCH_TIMEOUT, default 15, meaning the maximum number of FETCH cycles allowed without mem_rd_valid.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, a level sampled in IDLE that starts a program run.
REQ-008 SHALL have port halt_req, input, 1, a single-cycle stop request.
REQ-009 SHALL have port pc_addr, input, ADDR_W, the current program-counter value.
REQ-010 SHALL have port mem_rd_valid, input, 1, meaning instruction memory data is valid this cycle.
REQ-011 SHALL have port mem_rd_data, input, INSTR_W, the instruction memory read data.
REQ-012 SHALL have port exec_done, input, 1, the execute unit's completion pulse.
REQ-013 SHALL have port state_out, output, 2, the FSM state that drives the program counter's state input.
REQ-014 SHALL have port instr_out, output, INSTR_W, the latched instruction.
REQ-015 SHALL have port instr_valid, output, 1, a one-cycle pulse when instr_out is updated.
REQ-016 SHALL have port exec_start, output, 1, a one-cycle pulse that launches the execute unit.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done, output, 1, a one-cycle pulse at the end of a run.
REQ-019 SHALL have port error, output, 1, a sticky fetch-timeout flag.

Function
REQ-020 SHALL encode its states as IDLE=0, FETCH=1, INCREMENT=2 and EXECUTE=3; FETCH is the program counter's read-enable state and INCREMENT is its increment state.
REQ-021 In IDLE with start=1, SHALL clear error, then go to FETCH if pc_addr<MAX_COUNT, otherwise pulse done and remain in IDLE.
REQ-022 SHALL remain in FETCH until mem_rd_valid=1, then latch mem_rd_data into instr_out, pulse instr_valid in the same cycle and go to INCREMENT.
REQ-023 SHALL keep FETCH latency unbounded up to FETCH_TIMEOUT; the wait counter SHALL clear on every FETCH entry.
REQ-024 SHALL, when the FETCH wait count reaches FETCH_TIMEOUT without mem_rd_valid, set error and go to IDLE with no done pulse.
REQ-025 When mem_rd_valid=1 on the timeout cycle, SHALL treat the fetch as successful (valid wins).
REQ-026 SHALL stay in INCREMENT for exactly one cycle, then go to EXECUTE.
REQ-027 SHALL pulse exec_start on the first EXECUTE cycle only.
REQ-028 SHALL hold EXECUTE until exec_done=1; exec_done arriving in the same cycle as exec_start SHALL be accepted.
REQ-029 SHALL ignore exec_done outside EXECUTE.
REQ-030 On exec_done, SHALL go to IDLE with a done pulse if pc_addr>=MAX_COUNT or a halt is pending; otherwise it SHALL go to FETCH.
REQ-031 SHALL latch halt_req into a halt-pending flag in any non-IDLE state, and clear that flag when IDLE is entered.
REQ-032 A halt_req coincident with exec_done SHALL be honoured.
REQ-033 SHALL ignore halt_req in IDLE.
REQ-034 SHALL ignore start while busy=1.
REQ-035 SHALL compare the wait counter at $clog2(FETCH_TIMEOUT+1) bits and saturate it, with no wrap.
REQ-036 SHALL drive all outputs from registers, and SHALL drive state_out directly from the state register.

Reset
REQ-037 On rst_n=0, SHALL asynchronously force state IDLE, instr_out=0, instr_valid=0, exec_start=0, done=0, error=0, halt-pending=0 and wait counter=0.
REQ-038 A reset during any state SHALL abort the run with no done pulse; operation SHALL resume in IDLE on the first clock edge after rst_n rises.

Structure
REQ-039 SHALL place the state encodings (IDLE, FETCH, INCREMENT, EXECUTE) in a shared package used by this block and the program counter's RE_EN/INCREMENT parameters.
REQ-040 SHALL contain one sub-module, seq_timeout_counter, a saturating wait counter with clear/enable inputs and an expired output.
REQ-041 SHALL be implemented as a single FSM plus datapath registers, with no combinational path from any input to state_out.

Verification
REQ-042 Nominal run with MAX_COUNT=4: start with pc=0, mem_rd_valid 2 cycles into each FETCH and exec_done 3 cycles after each exec_start -> 4 instr_valid, 4 exec_start, pc reaches 4, then one done pulse and return to IDLE.
REQ-043 Timeout with FETCH_TIMEOUT=15: mem_rd_valid held low -> error=1 and IDLE after 15 FETCH cycles with no done pulse; a following start clears error.
REQ-044 Halt: halt_req pulsed during FETCH of instruction 2 -> instruction 2 completes execution, then done pulse, IDLE, pc=2.
REQ-045 Edge cases: exec_done in the same cycle as exec_start -> next state FETCH; mem_rd_valid on the 15th wait cycle -> fetch accepted, error=0.
REQ-046 Reset mid-EXECUTE: rst_n low -> all outputs 0 immediately, state_out=0, no done pulse; start while pc_addr=4 -> immediate done pulse with no FETCH.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer and the program counter.
// The PC decodes state_out directly, so the encodings here are fixed.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    INCREMENT = 2'd2,
    EXECUTE   = 2'd3
  } seq_state_e;

  // Program counter parameters: the state in which it drives the read
  // address, and the state in which it steps to the next instruction.
  localparam logic [1:0] PC_RE_EN     = 2'(FETCH);
  localparam logic [1:0] PC_INCREMENT = 2'(INCREMENT);

  typedef struct packed {
    logic instr_valid;
    logic exec_start;
    logic done;
    logic error;
    logic busy;
    logic halt_pend;
  } seq_flags_t;

  // A request arriving in the same cycle as the pending flag counts too.
  function automatic logic halt_seen(input logic pend, input logic req);
    return pend | req;
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Saturating FETCH wait counter. Ports: clk, rst_n, clr, en -> expired.
// expired is high in the LIMIT-th enabled cycle since clr, and after that.
module seq_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] SAT  = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // cnt_q holds the cycles already spent, so the current one is cnt_q+1.
  assign expired = en && (cnt_q >= LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: IDLE -> FETCH -> INCREMENT -> EXECUTE loop.
// In: start, halt_req, pc_addr, mem_rd_*, exec_done. Out: all registered.
module instr_sequencer #(
  parameter int ADDR_W        = 7,
  parameter int INSTR_W       = 16,
  parameter int MAX_COUNT     = 4,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               mem_rd_valid,
  input  logic [INSTR_W-1:0] mem_rd_data,
  input  logic               exec_done,
  output logic [1:0]         state_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               exec_start,
  output logic               busy,
  output logic               done,
  output logic               error
);

  import instr_sequencer_pkg::*;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MAX_COUNT);

  seq_state_e         state_q, state_n;
  logic [INSTR_W-1:0] instr_q, instr_n;
  seq_flags_t         flg_q, flg_n;

  logic pc_end;
  logic to_clr;
  logic to_en;
  logic to_expired;

  assign pc_end = {1'b0, pc_addr} >= LIMIT;
  assign to_en  = (state_q == FETCH);
  assign to_clr = (state_q != FETCH);

  seq_timeout_counter #(
    .LIMIT(FETCH_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (to_clr),
    .en     (to_en),
    .expired(to_expired)
  );

  always_comb begin
    state_n           = state_q;
    instr_n           = instr_q;
    flg_n             = flg_q;
    flg_n.instr_valid = 1'b0;
    flg_n.exec_start  = 1'b0;
    flg_n.done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          flg_n.error = 1'b0;
          if (pc_end) begin
            flg_n.done = 1'b1;
          end else begin
            state_n = FETCH;
          end
        end
      end
      FETCH: begin
        if (mem_rd_valid) begin
          instr_n           = mem_rd_data;
          flg_n.instr_valid = 1'b1;
          state_n           = INCREMENT;
        end else if (to_expired) begin
          flg_n.error = 1'b1;
          state_n     = IDLE;
        end
      end
      INCREMENT: begin
        flg_n.exec_start = 1'b1;
        state_n          = EXECUTE;
      end
      EXECUTE: begin
        if (exec_done) begin
          if (pc_end || halt_seen(flg_q.halt_pend, halt_req)) begin
            flg_n.done = 1'b1;
            state_n    = IDLE;
          end else begin
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if ((state_q != IDLE) && halt_req) begin
      flg_n.halt_pend = 1'b1;
    end
    if (state_n == IDLE) begin
      flg_n.halt_pend = 1'b0;
    end
    flg_n.busy = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_n;
      instr_q <= instr_n;
      flg_q   <= flg_n;
    end
  end

  assign state_out   = state_q;
  assign instr_out   = instr_q;
  assign instr_valid = flg_q.instr_valid;
  assign exec_start  = flg_q.exec_start;
  assign busy        = flg_q.busy;
  assign done        = flg_q.done;
  assign error       = flg_q.error;

endmodule
